// File: rtl/loader_pkg.sv
// loader_pkg: shared defaults and output FSM states for the loader write buffer
package loader_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int ADDR_W_DEF = 22;
  localparam int DATA_W_DEF = 8;
  typedef enum logic {IDLE, ISSUE} state_e;
endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: synchronous FIFO with occupancy count; caller never pushes when full without popping
module loader_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 30,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [LW-1:0] cnt_q, cnt_d;
  assign full = cnt_q == LW'(DEPTH);
  assign empty = cnt_q == '0;
  assign rdata = mem_q[rd_q];
  assign level = cnt_q;
  always_comb
    cnt_d = (push && !pop) ? cnt_q + LW'(1) : (pop && !push) ? cnt_q - LW'(1) : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + PW'(push);
      rd_q <= rd_q + PW'(pop);
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/loader_write_buffer.sv
// loader_write_buffer: queues loader writes and issues one per memory slot to SDRAM
module loader_write_buffer
  import loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_write,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              slot,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              wait_req,
  output logic [LW-1:0]     level,
  output logic              overflow
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic wait_q, ovf_q, ovf_d;
  logic full, empty, push, pop;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [LW-1:0] fifo_level;
  // a pop frees a slot in the same cycle, so a full FIFO still accepts alongside it
  assign pop = slot & ~empty;
  assign push = in_write & (~full | pop);
  loader_fifo #(.DEPTH(DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata({in_addr, in_data}),
    .rdata(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  always_comb begin
    state_d = slot ? (empty ? IDLE : ISSUE) : state_q;
    {addr_d, data_d} = pop ? head : {addr_q, data_q};
    ovf_d = ovf_q | (in_write & full & ~pop);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      wait_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wait_q <= fifo_level >= LW'(DEPTH - 1);
      ovf_q <= ovf_d;
    end
  assign mem_write = state_q == ISSUE;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign wait_req = wait_q;
  assign level = fifo_level;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_loader_write_buffer.sv
// tb_loader_write_buffer: scoreboard bench for loader_write_buffer
module tb_loader_write_buffer;
  logic clk = 0, reset = 1, in_write = 0, slot_en = 0, slot_force = 0, per_slot = 0;
  logic [21:0] in_addr = '0;
  logic [7:0] in_data = '0;
  logic slot, mem_write, wait_req, overflow;
  logic [21:0] mem_addr;
  logic [7:0] mem_data;
  logic [2:0] level;
  logic [29:0] sb[$];
  int checks = 0, failures = 0;
  int max_lvl = 0;
  assign slot = slot_en ? per_slot : slot_force;
  always #5 clk = ~clk;
  loader_write_buffer dut (
    .clk(clk), .reset(reset), .in_write(in_write), .in_addr(in_addr), .in_data(in_data),
    .slot(slot), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .wait_req(wait_req), .level(level), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial begin
    int sc = 0;
    forever begin
      @(posedge clk);
      #1;
      sc++;
      per_slot = (sc % 4 == 0);
    end
  end
  initial begin
    logic sp;
    forever begin
      @(posedge clk);
      sp = slot && !reset;
      @(negedge clk);
      if (sp && mem_write && !reset) begin
        if (sb.size() == 0) chk("unexpected_issue", 1, 0);
        else chk("issue", {mem_addr, mem_data}, sb.pop_front());
      end
    end
  end
  task automatic cyc();
    @(negedge clk);
    if (int'(level) > max_lvl) max_lvl = int'(level);
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [21:0] a, input logic [7:0] d, input bit acc);
    in_write = 1;
    in_addr = a;
    in_data = d;
    if (acc) sb.push_back({a, d});
    @(posedge clk);
    #1;
    in_write = 0;
  endtask
  task automatic drain(input string tag);
    int n = 0;
    slot_en = 1;
    while (sb.size() != 0 && n < 80) begin
      cyc();
      n++;
    end
    if (n >= 80) chk({tag, "_drain_timeout"}, sb.size(), 0);
    repeat (12) cyc();
  endtask
  task automatic do_reset();
    reset = 1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask
  initial begin
    int n;
    #2;
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_wait_req", wait_req, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    do_reset();
    // single write, slot every 4 cycles
    slot_en = 1;
    wr(22'h000010, 8'hA5, 1);
    n = 0;
    @(negedge clk);
    while (!mem_write && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("single_seen", mem_write, 1);
    n = 0;
    while (mem_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("single_len", n, 4);
    @(posedge clk);
    #1;
    drain("single");
    // burst of four with no slots
    slot_en = 0;
    wr(22'h000100, 8'h11, 1);
    wr(22'h000101, 8'h22, 1);
    @(negedge clk);
    chk("burst_wait_lo", wait_req, 0);
    @(posedge clk);
    #1;
    wr(22'h000102, 8'h33, 1);
    wr(22'h000103, 8'h44, 1);
    @(negedge clk);
    chk("burst_level", level, 4);
    chk("burst_wait_hi", wait_req, 1);
    chk("burst_ovf", overflow, 0);
    @(posedge clk);
    #1;
    drain("burst");
    chk("burst_ovf_after", overflow, 0);
    chk("burst_level_after", level, 0);
    chk("burst_idle", mem_write, 0);
    // overflow: fifth write dropped
    slot_en = 0;
    for (int i = 0; i < 5; i++) wr(22'h000200 + 22'(i), 8'hB0 + 8'(i), i < 4);
    @(negedge clk);
    chk("ovf_level", level, 4);
    chk("ovf_flag", overflow, 1);
    @(posedge clk);
    #1;
    drain("ovf");
    chk("ovf_sticky", overflow, 1);
    do_reset();
    chk("ovf_cleared", overflow, 0);
    // push and pop together at full
    slot_en = 0;
    for (int i = 0; i < 4; i++) wr(22'h000300 + 22'(i), 8'hC0 + 8'(i), 1);
    in_write = 1;
    in_addr = 22'h0003FF;
    in_data = 8'hCF;
    slot_force = 1;
    sb.push_back({22'h0003FF, 8'hCF});
    @(posedge clk);
    #1;
    in_write = 0;
    slot_force = 0;
    @(negedge clk);
    chk("simul_level", level, 4);
    chk("simul_ovf", overflow, 0);
    @(posedge clk);
    #1;
    drain("simul");
    // reset in the middle of a burst
    slot_en = 0;
    for (int i = 0; i < 4; i++) wr(22'h000400 + 22'(i), 8'hD0 + 8'(i), 1);
    slot_force = 1;
    @(posedge clk);
    #1;
    slot_force = 0;
    @(negedge clk);
    chk("mid_level", level, 3);
    chk("mid_mem_write", mem_write, 1);
    #2;
    reset = 1;
    sb.delete();
    #1;
    chk("arst_mem_write", mem_write, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_data", mem_data, 0);
    chk("arst_wait_req", wait_req, 0);
    chk("arst_level", level, 0);
    chk("arst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    reset = 0;
    slot_en = 1;
    n = 0;
    repeat (14) begin
      @(negedge clk);
      if (mem_write) n++;
    end
    chk("post_reset_writes", n, 0);
    @(posedge clk);
    #1;
    // wrap: ten spaced writes
    max_lvl = 0;
    for (int i = 0; i < 10; i++) begin
      wr(22'h000500 + 22'(i), 8'(i), 1);
      repeat (7) cyc();
    end
    drain("wrap");
    chk("wrap_max_level", max_lvl, 1);
    chk("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/loader_write_buffer.md
LOADER_WRITE_BUFFER -- requirements
Module: loader_write_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, >= 2).
REQ-002 The block SHALL have parameter ADDR_W, default 22, meaning memory address width.
REQ-003 The block SHALL have parameter DATA_W, default 8, meaning write data width.
REQ-004 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port in_write  input  1  one-cycle write pulse from the game loader.
REQ-007 The block SHALL have port in_addr  input  ADDR_W  write address, valid with in_write.
REQ-008 The block SHALL have port in_data  input  DATA_W  write byte, valid with in_write.
REQ-009 The block SHALL have port slot  input  1  one-cycle memory-slot strobe (NES clock-enable phase 3).
REQ-010 The block SHALL have port mem_write  output  1  write request to SDRAM controller.
REQ-011 The block SHALL have port mem_addr  output  ADDR_W  address presented with mem_write.
REQ-012 The block SHALL have port mem_data  output  DATA_W  data presented with mem_write.
REQ-013 The block SHALL have port wait_req  output  1  back-pressure to the download source (ioctl_wait).
REQ-014 The block SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 The block SHALL have port overflow  output  1  sticky flag: a write was dropped.

Function
REQ-016 The block SHALL push {in_addr,in_data} into the FIFO on every cycle with in_write=1 while level<DEPTH.
REQ-017 The block SHALL drop in_write when level==DEPTH and no pop occurs that cycle, set overflow=1, leave level unchanged.
REQ-018 The block SHALL accept a push when full if a pop occurs in the same cycle; level stays DEPTH.
REQ-019 The output FSM SHALL have two states: IDLE (mem_write=0) and ISSUE (mem_write=1).
REQ-020 On slot=1 with FIFO non-empty, the FSM SHALL pop the head into mem_addr/mem_data and enter/stay in ISSUE from the next cycle.
REQ-021 On slot=1 with FIFO empty, the FSM SHALL enter IDLE from the next cycle; mem_addr/mem_data hold last values.
REQ-022 Without slot, the FSM and output registers SHALL hold; mem_write therefore lasts exactly one slot period.
REQ-023 The FIFO SHALL not bypass: an entry pushed in the same cycle as slot on an empty FIFO SHALL issue at the following slot.
REQ-024 Simultaneous push and pop SHALL leave level unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-025 wait_req SHALL be registered and equal (level >= DEPTH-1) as of the previous cycle.
REQ-026 Entries SHALL issue strictly in push order.

Reset
REQ-027 While reset=1, mem_write, mem_addr, mem_data, wait_req, level, overflow SHALL be 0, pointers 0, FSM in IDLE.
REQ-028 Reset asserted mid-operation SHALL discard all buffered and in-flight writes; no write SHALL issue after release until a new push.
REQ-029 overflow SHALL clear only on reset.

Structure
REQ-030 A shared package loader_pkg SHALL hold the default DEPTH/ADDR_W/DATA_W constants and the IDLE/ISSUE state enum.
REQ-031 Storage SHALL be a sub-module loader_fifo (synchronous FIFO with push, pop, full, empty, level); the FSM and flags stay in loader_write_buffer.

Verification
REQ-032 Single write: in_write with addr 22'h000010, data 8'hA5, slot every 4 cycles -> mem_write=1 for exactly 4 cycles starting cycle after next slot, mem_addr=22'h000010, mem_data=8'hA5.
REQ-033 Burst: 4 writes on consecutive cycles, DEPTH=4 -> level reaches 4, wait_req=1, four in-order issues one per slot period, overflow stays 0.
REQ-034 Overflow: 5 writes on consecutive cycles with no slot -> level=4, overflow=1, fifth write never issues.
REQ-035 Simultaneous: in_write and slot in same cycle at level=4 -> push accepted, level stays 4, overflow 0.
REQ-036 Reset mid-burst: reset asserted at level=3 while mem_write=1 -> all outputs 0 asynchronously; after release, no mem_write across 3 slots.
REQ-037 Wrap: 10 writes of data 0..9 spaced 8 cycles apart, slot every 4 -> data issued 0..9 in order, level never exceeds 1.
